logic_unit_arbiter: RTL and testbench

Shares one N-bit bitwise logic unit (NOT/AND/OR/XOR) between two requesters using round-robin arbitration. Each requester has a valid/ready request channel. All requesters share one valid/ready response channel that carries the requester ID. The block sits beside the lab ALU datapath and sequences the structural logic slice so that two masters (e.g. control unit and test harness) can use it without contention.

---
 rtl/lu_arb_pkg.sv | 33 +++
 rtl/logic_unit_arbiter_logic_unit.sv | 36 +++
 rtl/logic_unit_arbiter.sv | 144 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_arb_pkg.sv
// Shared types and constants for the round-robin logic-unit arbiter.
package lu_arb_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned STAT_W = 32;

    localparam logic [OP_W-1:0] OP_NOT = 2'b00;
    localparam logic [OP_W-1:0] OP_AND = 2'b01;
    localparam logic [OP_W-1:0] OP_OR  = 2'b10;
    localparam logic [OP_W-1:0] OP_XOR = 2'b11;

    localparam logic LAST_ID_RST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    function automatic logic grant_id(input logic v0, input logic v1, input logic last_id);
        logic id;
        if (v0 && v1) begin
            id = ~last_id;
        end else if (v1) begin
            id = 1'b1;
        end else begin
            id = 1'b0;
        end
        return id;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Combinational N-bit bitwise logic unit: per-bit NOT/AND/OR/XOR slices into a 4:1 mux.
module logic_unit
    import lu_arb_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [OP_W-1:0] op,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    output logic [N-1:0]    y
);

    logic [N-1:0] w_not;
    logic [N-1:0] w_and;
    logic [N-1:0] w_or;
    logic [N-1:0] w_xor;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign w_not[i] = ~a[i];
        assign w_and[i] = a[i] & b[i];
        assign w_or[i]  = a[i] | b[i];
        assign w_xor[i] = a[i] ^ b[i];
    end

    always_comb begin
        y = w_not;
        case (op)
            OP_NOT:  y = w_not;
            OP_AND:  y = w_and;
            OP_OR:   y = w_or;
            OP_XOR:  y = w_xor;
            default: y = w_not;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for one shared bitwise logic unit.
// Optional statistics outputs are enabled with `define LU_ARB_STATS_EN.
module logic_unit_arbiter
    import lu_arb_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [N-1:0]      req0_a,
    input  logic [N-1:0]      req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [N-1:0]      req1_a,
    input  logic [N-1:0]      req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [N-1:0]      rsp_data,
`ifdef LU_ARB_STATS_EN
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1,
    output logic [STAT_W-1:0] busy_cycles,
`endif
    output logic              rsp_zero
);

    state_t          r_state;
    logic            r_last_id;
    logic            r_id;
    logic [OP_W-1:0] r_op;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [N-1:0]    r_rsp_data;
    logic            r_rsp_zero;

    logic            w_idle;
    logic            w_gid;
    logic            w_acc0;
    logic            w_acc1;
    logic [N-1:0]    w_y;

    // Grant is decided from the valids seen during the IDLE cycle only.
    assign w_idle     = (r_state == IDLE);
    assign w_gid      = grant_id(req0_valid, req1_valid, r_last_id);
    assign w_acc0     = w_idle && req0_valid && !w_gid;
    assign w_acc1     = w_idle && req1_valid &&  w_gid;
    assign req0_ready = w_acc0;
    assign req1_ready = w_acc1;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_zero   = r_rsp_zero;

    logic_unit #(.N(N)) u_lu (
        .op (r_op),
        .a  (r_a),
        .b  (r_b),
        .y  (w_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_id   <= LAST_ID_RST;
            r_id        <= 1'b0;
            r_op        <= OP_NOT;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc0 || w_acc1) begin
                        r_op      <= w_acc1 ? req1_op : req0_op;
                        r_a       <= w_acc1 ? req1_a  : req0_a;
                        r_b       <= w_acc1 ? req1_b  : req0_b;
                        r_id      <= w_acc1;
                        r_last_id <= w_acc1;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_y;
                    r_rsp_zero  <= (w_y == '0);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    // Response registers are left untouched until the consumer takes them.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

`ifdef LU_ARB_STATS_EN
    logic [STAT_W-1:0] r_grant_cnt0;
    logic [STAT_W-1:0] r_grant_cnt1;
    logic [STAT_W-1:0] r_busy_cycles;

    assign grant_cnt0  = r_grant_cnt0;
    assign grant_cnt1  = r_grant_cnt1;
    assign busy_cycles = r_busy_cycles;

    // Free-running wrap-around usage counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt0  <= '0;
            r_grant_cnt1  <= '0;
            r_busy_cycles <= '0;
        end else begin
            if (w_acc0) begin
                r_grant_cnt0 <= r_grant_cnt0 + STAT_W'(1);
            end
            if (w_acc1) begin
                r_grant_cnt1 <= r_grant_cnt1 + STAT_W'(1);
            end
            if (r_state == EXEC || r_state == DONE) begin
                r_busy_cycles <= r_busy_cycles + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (build with +define+LU_ARB_STATS_EN to cover counters).
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [1:0]  req0_op = 2'b00;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [1:0]  req1_op = 2'b00;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_zero;
`ifdef LU_ARB_STATS_EN
    logic [31:0] grant_cnt0;
    logic [31:0] grant_cnt1;
    logic [31:0] busy_cycles;
`endif

    logic_unit_arbiter #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
`ifdef LU_ARB_STATS_EN
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .busy_cycles(busy_cycles),
`endif
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed vectors per requester: op, a, b, expected y.
    logic [1:0]  t0_op [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [31:0] t0_a  [4] = '{32'hF0F0_F0F0, 32'h1234_0000, 32'hAAAA_5555, 32'h0000_FFFF};
    logic [31:0] t0_b  [4] = '{32'hFF00_FF00, 32'h0000_5678, 32'hFFFF_0000, 32'hDEAD_BEEF};
    logic [31:0] t0_y  [4] = '{32'hF000_F000, 32'h1234_5678, 32'h5555_5555, 32'hFFFF_0000};
    logic [1:0]  t1_op [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    logic [31:0] t1_a  [4] = '{32'hFFFF_FFFF, 32'h1357_9BDF, 32'h0F0F_0F0F, 32'h8000_0000};
    logic [31:0] t1_b  [4] = '{32'h1234_5678, 32'h1357_9BDF, 32'h3C3C_3C3C, 32'h0000_0001};
    logic [31:0] t1_y  [4] = '{32'h0000_0000, 32'h0000_0000, 32'h0C0C_0C0C, 32'h8000_0001};

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q [$];
    int          acc_id_q [$];
    int          acc_cyc_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive table entries until each requester reaches its limit and all responses drain.
    task automatic run_ops(input int s0, input int l0, input int s1, input int l1, input int max_cyc);
        int          i0 = s0;
        int          i1 = s1;
        int          n  = 0;
        bit          a0;
        bit          a1;
        logic [32:0] e;
        while ((i0 < l0 || i1 < l1 || exp_q.size() != 0) && n < max_cyc) begin
            req0_valid = (i0 < l0);
            req1_valid = (i1 < l1);
            if (i0 < l0) begin
                req0_op = t0_op[i0]; req0_a = t0_a[i0]; req0_b = t0_b[i0];
            end
            if (i1 < l1) begin
                req1_op = t1_op[i1]; req1_a = t1_a[i1]; req1_b = t1_b[i1];
            end
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0 && a1) check("single_grant", 32'(a0 && a1), 32'd0);
            if (a0) begin
                exp_q.push_back({1'b0, t0_y[i0]});
                acc_id_q.push_back(0);
                acc_cyc_q.push_back(cyc);
            end
            if (a1) begin
                exp_q.push_back({1'b1, t1_y[i1]});
                acc_id_q.push_back(1);
                acc_cyc_q.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id",   32'(rsp_id), 32'(e[32]));
                    check("rsp_data", rsp_data, e[31:0]);
                    check("rsp_zero", 32'(rsp_zero), 32'(e[31:0] == 32'd0));
                end
            end
            @(posedge clk); #1;
            if (a0) i0++;
            if (a1) i1++;
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (n >= max_cyc) check("run_timeout", 32'(n), 32'(max_cyc - 1));
    endtask

    task automatic step_neg();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        check("rst_rsp_zero",  32'(rsp_zero),  32'd0);
        check("rst_ready0",    32'(req0_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single AND from requester 0; rsp_ready high early must be ignored.
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_op = t0_op[0]; req0_a = t0_a[0]; req0_b = t0_b[0];
        @(negedge clk);
        check("t1_ready0", 32'(req0_ready), 32'd1);
        check("t1_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = t1_op[2]; req1_a = t1_a[2]; req1_b = t1_b[2];
        @(negedge clk);
        check("t1_exec_valid",  32'(rsp_valid),  32'd0);
        check("t1_exec_ready1", 32'(req1_ready), 32'd0);
        req1_valid = 1'b0;
        step_neg();
        check("t1_valid", 32'(rsp_valid), 32'd1);
        check("t1_data",  rsp_data,       32'hF000_F000);
        check("t1_id",    32'(rsp_id),    32'd0);
        check("t1_zero",  32'(rsp_zero),  32'd0);
        check("t1_done_ready1", 32'(req1_ready), 32'd0);
        step_neg();
        check("t1_back_idle", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // NOT of all-ones from requester 1 gives a zero result.
        run_ops(0, 0, 0, 1, 20);

        // Tie with round robin: order 0,1,0,1,0,1 spaced 3 cycles apart.
        acc_id_q.delete(); acc_cyc_q.delete();
        run_ops(1, 4, 1, 4, 60);
        check("rr_count", 32'(acc_id_q.size()), 32'd6);
        for (int k = 0; k < acc_id_q.size(); k++) begin
            check("rr_order", 32'(acc_id_q[k]), 32'(k % 2));
            if (k > 0) check("rr_spacing", 32'(acc_cyc_q[k] - acc_cyc_q[k-1]), 32'd3);
        end

        // Backpressure: 5 stalled DONE cycles with requester 1 waiting.
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = t0_op[2]; req0_a = t0_a[2]; req0_b = t0_b[2];
        @(negedge clk);
        check("bp_ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = t1_op[3]; req1_a = t1_a[3]; req1_b = t1_b[3];
        @(negedge clk);
        check("bp_exec_valid", 32'(rsp_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step_neg();
            check("bp_valid",  32'(rsp_valid),  32'd1);
            check("bp_data",   rsp_data,        32'h5555_5555);
            check("bp_id",     32'(rsp_id),     32'd0);
            check("bp_ready1", 32'(req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid",  32'(rsp_valid),  32'd1);
        check("bp_hs_ready1", 32'(req1_ready), 32'd0);
        step_neg();
        check("bp_idle_valid",  32'(rsp_valid),  32'd0);
        check("bp_idle_ready1", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        step_neg();
        check("bp_r1_data", rsp_data,     32'h8000_0001);
        check("bp_r1_id",   32'(rsp_id),  32'd1);
        @(posedge clk); #1;

        // Reset during EXEC drops the op; afterwards requester 0 wins the tie.
        req1_valid = 1'b1; req1_op = t1_op[2]; req1_a = t1_a[2]; req1_b = t1_b[2];
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rm_valid_in_rst", 32'(rsp_valid), 32'd0);
        step_neg();
        check("rm_valid_in_rst2", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rm_valid_after", 32'(rsp_valid), 32'd0);
        check("rm_data_after",  rsp_data,       32'd0);
        @(posedge clk); #1;
        acc_id_q.delete(); acc_cyc_q.delete();
        run_ops(0, 1, 0, 1, 30);
        check("rm_first_grant", 32'(acc_id_q.size() > 0 ? acc_id_q[0] : 9), 32'd0);

`ifdef LU_ARB_STATS_EN
        // Counters after a clean reset: 3 ops from requester 0, 2 from requester 1.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_ops(0, 3, 0, 2, 100);
        check("st_grant0", grant_cnt0,  32'd3);
        check("st_grant1", grant_cnt1,  32'd2);
        check("st_busy",   busy_cycles, 32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
